neuron_mac: RTL and testbench

- Upstream feeder of the sigmoid lookup stage in one hidden/output-layer neuron.
- Streams `numInputs` signed activations and multiplies each by a weight held in an internal weight RAM. Accumulates the products, adds a bias, scales, and saturates.
- Emits one signed `inWidth`-bit word per frame: the sigmoid ROM address operand `x`.
- Also emits a valid delayed by one extra cycle, aligned to the sigmoid ROM's one-cycle registered lookup.

---
 rtl/neuron_mac.sv | 150 +++++++++++++++
 tb/tb_neuron_mac.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate front end: weight RAM, MAC pipeline, bias, scale and clamp feeding the sigmoid ROM.
// Define NEURON_SAT_FLAG_EN to add the sat_flag output reporting a clamped result.
module neuron_mac #(
    parameter int dataWidth = 16,
    parameter int numInputs = 784,
    parameter int inWidth   = 10,
    parameter int accShift  = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [dataWidth-1:0]         in_data,
    output logic                         in_ready,
    input  logic                         w_wr_en,
    input  logic [$clog2(numInputs)-1:0] w_wr_addr,
    input  logic [dataWidth-1:0]         w_wr_data,
    input  logic [2*dataWidth-1:0]       bias,
    output logic [inWidth-1:0]           sig_x,
    output logic                         sig_x_valid,
    output logic                         act_valid
`ifdef NEURON_SAT_FLAG_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam int CntW  = $clog2(numInputs);
    localparam int ProdW = 2 * dataWidth;
    localparam int AccW  = ProdW + CntW;
    localparam logic [CntW-1:0] LastIdx = CntW'(numInputs - 1);
    localparam logic signed [AccW-1:0] SatMax = {{(AccW-inWidth+1){1'b0}}, {(inWidth-1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {S_ACC, S_DRAIN, S_OUT} state_t;

    state_t                      state_q, state_d;
    logic                        drain_q, drain_d;
    logic [CntW-1:0]             cnt_q;
    logic signed [dataWidth-1:0] data_q, weight_q;
    logic signed [ProdW-1:0]     prod_q;
    logic                        v1_q, v2_q;
    logic signed [AccW-1:0]      acc_q;
    logic signed [AccW-1:0]      sum, scaled;
    logic                        overMax, underMin;
    logic [inWidth-1:0]          sigX_q, sigX_d;
    logic                        sigXValid_q, actValid_q;
    logic                        xfer;
    logic signed [dataWidth-1:0] wMem [numInputs];

    assign in_ready = (state_q == S_ACC);
    assign xfer     = in_valid & in_ready;

    // Read-before-write: a same-cycle write to the address being read returns the old weight.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            wMem[w_wr_addr] <= w_wr_data;
        end
        if (xfer) begin
            weight_q <= wMem[cnt_q];
            data_q   <= in_data;
        end
        if (v1_q) begin
            prod_q <= ProdW'(data_q) * ProdW'(weight_q);
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_ACC: begin
                if (xfer && (cnt_q == LastIdx)) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_OUT;
                end
            end
            S_OUT:   state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    assign sum      = acc_q + AccW'($signed(bias));
    assign scaled   = sum >>> accShift;
    assign overMax  = (scaled > SatMax);
    assign underMin = (scaled < SatMin);

    always_comb begin
        sigX_d = scaled[inWidth-1:0];
        if (overMax) begin
            sigX_d = SatMax[inWidth-1:0];
        end else if (underMin) begin
            sigX_d = SatMin[inWidth-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            drain_q     <= 1'b0;
            cnt_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            sigX_q      <= '0;
            sigXValid_q <= 1'b0;
            actValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            v1_q        <= xfer;
            v2_q        <= v1_q;
            sigXValid_q <= (state_q == S_OUT);
            actValid_q  <= sigXValid_q;
            if (xfer) begin
                cnt_q <= (cnt_q == LastIdx) ? '0 : cnt_q + CntW'(1);
            end
            if (state_q == S_OUT) begin
                acc_q  <= '0;
                sigX_q <= sigX_d;
            end else if (v2_q) begin
                acc_q <= acc_q + AccW'(prod_q);
            end
        end
    end

    assign sig_x       = sigX_q;
    assign sig_x_valid = sigXValid_q;
    assign act_valid   = actValid_q;

`ifdef NEURON_SAT_FLAG_EN
    logic satFlag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            satFlag_q <= 1'b0;
        end else if (state_q == S_OUT) begin
            satFlag_q <= overMax | underMin;
        end
    end

    assign sat_flag = satFlag_q;
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: table-driven frames, hand-written reset sequence and random frames
// compared against a plain-arithmetic dot-product model.
module tb_neuron_mac;

    localparam int DataW    = 16;
    localparam int NumIn    = 4;
    localparam int InW      = 10;
    localparam int AccShift = 0;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [DataW-1:0]         in_data;
    logic                     in_ready;
    logic                     w_wr_en;
    logic [1:0]               w_wr_addr;
    logic [DataW-1:0]         w_wr_data;
    logic [2*DataW-1:0]       bias;
    logic signed [InW-1:0]    sig_x;
    logic                     sig_x_valid;
    logic                     act_valid;
`ifdef NEURON_SAT_FLAG_EN
    logic                     sat_flag;
`endif

    neuron_mac #(
        .dataWidth(DataW),
        .numInputs(NumIn),
        .inWidth  (InW),
        .accShift (AccShift)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .w_wr_en    (w_wr_en),
        .w_wr_addr  (w_wr_addr),
        .w_wr_data  (w_wr_data),
        .bias       (bias),
        .sig_x      (sig_x),
        .sig_x_valid(sig_x_valid),
        .act_valid  (act_valid)
`ifdef NEURON_SAT_FLAG_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][15:0] w;
        logic [3:0][15:0] x;
        logic [31:0]      b;
        logic [3:0]       gap;
        logic             load;
        logic             junk;
        logic             wr;
        logic [15:0]      wrData;
        logic [9:0]       expX;
        logic             expSat;
    } vec_t;

    int   nChecks = 0;
    int   nFail   = 0;
    int   mW [NumIn];
    int   prevX;
    vec_t vecs [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic loadWeights(input logic [3:0][15:0] ws);
        for (int i = 0; i < NumIn; i++) begin
            w_wr_en   = 1'b1;
            w_wr_addr = 2'(i);
            w_wr_data = ws[i];
            step();
            mW[i] = int'($signed(ws[i]));
        end
        w_wr_en = 1'b0;
    endtask

    // Reference: dot product plus bias, arithmetic shift, clamp to the signed inWidth range.
    function automatic void refModel(input logic [3:0][15:0] xs, input int b, output int x, output bit sat);
        longint s = longint'(b);
        for (int i = 0; i < NumIn; i++) begin
            s += longint'(mW[i]) * longint'($signed(xs[i]));
        end
        s   = s >>> AccShift;
        sat = (s > 511) || (s < -512);
        x   = (s > 511) ? 511 : (s < -512) ? -512 : int'(s);
    endfunction

    task automatic applyStimulus(input logic [3:0][15:0] xs, input logic [31:0] b, input int gap, input bit junk,
                                 input bit wr, input logic [15:0] wrData, input int expX, input bit expSat,
                                 input string tag);
        int got;
        int guard;
        bias = b;
        for (int i = 0; i < NumIn; i++) begin
            in_valid = 1'b0;
            repeat (gap) step();
            in_valid = 1'b1;
            in_data  = xs[i];
            if (i == 0 && wr) begin
                w_wr_en   = 1'b1;
                w_wr_addr = 2'd0;
                w_wr_data = wrData;
            end
            guard = 0;
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            if (guard == 20) checkOutput({tag, " in_ready timeout"}, 0, 1);
            step();
            w_wr_en = 1'b0;
        end
        got = 0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) step();
            in_valid = junk && (n < 3);
            in_data  = 16'h7fff;
            if (sig_x_valid) begin
                got = n;
                break;
            end
            if (n <= 3) begin
                checkOutput($sformatf("%s in_ready drain%0d", tag, n), 64'(in_ready), 0);
                checkOutput($sformatf("%s sig_x hold%0d", tag, n), sig_x, 64'(prevX));
            end
        end
        in_valid = 1'b0;
        checkOutput({tag, " latency"}, 64'(got), 4);
        if (got != 0) begin
            checkOutput({tag, " in_ready back"}, 64'(in_ready), 1);
            checkOutput({tag, " sig_x"}, sig_x, 64'(expX));
`ifdef NEURON_SAT_FLAG_EN
            checkOutput({tag, " sat_flag"}, 64'(sat_flag), 64'(expSat));
`endif
            checkOutput({tag, " act_valid early"}, 64'(act_valid), 0);
            step();
            checkOutput({tag, " sig_x_valid width"}, 64'(sig_x_valid), 0);
            checkOutput({tag, " act_valid"}, 64'(act_valid), 1);
            step();
            checkOutput({tag, " act_valid width"}, 64'(act_valid), 0);
        end
        prevX = expX;
    endtask

    function automatic vec_t mkVec(int w0, int w1, int w2, int w3, int x0, int x1, int x2, int x3, int b, int gap,
                                   bit load, bit junk, bit wr, int wrData, int expX, bit expSat);
        vec_t v;
        v.w      = {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
        v.x      = {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
        v.b      = 32'(b);
        v.gap    = 4'(gap);
        v.load   = load;
        v.junk   = junk;
        v.wr     = wr;
        v.wrData = 16'(wrData);
        v.expX   = 10'(expX);
        v.expSat = expSat;
        return v;
    endfunction

    initial begin
        logic [3:0][15:0] ws;
        logic [3:0][15:0] xs;
        int               ex;
        bit               es;
        int               pulses;
        int               rb;

        vecs[0]  = mkVec(1, 2, 3, 4,        1, 1, 1, 1,            0,    0, 1, 0, 0, 0,  10, 0);
        vecs[1]  = mkVec(-2, 3, 0, 5,       4, -1, 7, -3,          -1,   0, 1, 0, 0, 0, -27, 0);
        vecs[2]  = mkVec(100, 100, 100, 100, 100, 100, 100, 100,    0,    0, 1, 0, 0, 0, 511, 1);
        vecs[3]  = mkVec(100, 100, 100, 100, -100, -100, -100, -100, 0,   0, 1, 0, 0, 0, -512, 1);
        vecs[4]  = mkVec(1, 1, 1, 1,        100, 100, 100, 211,    0,    0, 1, 0, 0, 0, 511, 0);
        vecs[5]  = mkVec(1, 1, 1, 1,        100, 100, 100, 212,    0,    0, 1, 0, 0, 0, 511, 1);
        vecs[6]  = mkVec(1, 1, 1, 1,        -128, -128, -128, -128, 0,   0, 1, 0, 0, 0, -512, 0);
        vecs[7]  = mkVec(1, 1, 1, 1,        -128, -128, -128, -129, 0,   0, 1, 0, 0, 0, -512, 1);
        vecs[8]  = mkVec(1, 1, 1, 1,        0, 0, 0, 0,            300,  0, 1, 0, 0, 0, 300, 0);
        vecs[9]  = mkVec(1, 2, 3, 4,        1, 1, 1, 1,            0,    3, 1, 0, 0, 0,  10, 0);
        vecs[10] = mkVec(1, 2, 3, 4,        1, 1, 1, 1,            0,    0, 0, 1, 0, 0,  10, 0);
        vecs[11] = mkVec(1, 2, 3, 4,        1, 1, 1, 1,            0,    0, 0, 0, 0, 0,  10, 0);
        vecs[12] = mkVec(1, 2, 3, 4,        1, 1, 1, 1,            0,    0, 1, 0, 1, 9,  10, 0);
        vecs[13] = mkVec(1, 2, 3, 4,        1, 1, 1, 1,            0,    0, 0, 0, 0, 0,  18, 0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        bias      = '0;
        prevX     = 0;
        for (int i = 0; i < NumIn; i++) mW[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset sig_x", sig_x, 0);
        checkOutput("reset sig_x_valid", 64'(sig_x_valid), 0);
        checkOutput("reset act_valid", 64'(act_valid), 0);
`ifdef NEURON_SAT_FLAG_EN
        checkOutput("reset sat_flag", 64'(sat_flag), 0);
`endif
        rst_n = 1'b1;
        step();
        checkOutput("reset in_ready", 64'(in_ready), 1);

        for (int k = 0; k < 14; k++) begin
            if (vecs[k].load) loadWeights(vecs[k].w);
            applyStimulus(vecs[k].x, vecs[k].b, int'(vecs[k].gap), vecs[k].junk, vecs[k].wr, vecs[k].wrData,
                          int'($signed(vecs[k].expX)), vecs[k].expSat, $sformatf("vec%0d", k));
            if (vecs[k].wr) mW[0] = int'($signed(vecs[k].wrData));
        end

        // Reset after two transfers: the partial frame must vanish without a pulse.
        for (int i = 0; i < NumIn; i++) ws[i] = 16'(i + 1);
        loadWeights(ws);
        bias     = '0;
        in_valid = 1'b1;
        in_data  = 16'd1;
        step();
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midreset sig_x", sig_x, 0);
        checkOutput("midreset sig_x_valid", 64'(sig_x_valid), 0);
        step();
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            step();
            if (sig_x_valid) pulses++;
        end
        checkOutput("midreset no pulse", 64'(pulses), 0);
        prevX = 0;
        for (int i = 0; i < NumIn; i++) xs[i] = 16'd1;
        applyStimulus(xs, 32'd0, 0, 1'b0, 1'b0, 16'd0, 10, 1'b0, "after midreset");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NumIn; i++) begin
                ws[i] = 16'(int'($urandom_range(30)) - 15);
                xs[i] = 16'(int'($urandom_range(30)) - 15);
            end
            rb = int'($urandom_range(800)) - 400;
            loadWeights(ws);
            refModel(xs, rb, ex, es);
            applyStimulus(xs, 32'(rb), int'($urandom_range(2)), 1'($urandom_range(1)), 1'b0, 16'd0, ex, es,
                          $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
